cp0_exception_unit: RTL and testbench
=====================================

// Module: cp0_exception_unit
// PURPOSE
//  CP0 register file plus exception/interrupt commit logic at the MEM stage.
//  - Consumes the victim address and delay-slot flag from the victim-instruction detector.
//  - Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  - Arbitrates interrupts, synchronous exceptions and ERET.
//  - Drives a registered pipeline flush and redirect PC.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  redirect PC for all exceptions and interrupts
//  COUNT_DIV   2              Count increments once every COUNT_DIV cycles (>=1)
// PORTS
//  clk              in   1   clock; all state updates on the rising edge
//  rst              in   1   synchronous reset, active-high
//  hw_int           in   6   hardware interrupt lines, level-sensitive
//  exc_valid        in   1   synchronous exception raised by the MEM-stage instruction
//  exc_code         in   5   ExcCode for exc_valid
//  exc_badvaddr_we  in   1   exception carries a bad address (AdEL/AdES)
//  exc_badvaddr     in   32  faulting virtual address
//  vic_inst_addr    in   32  victim instruction address
//  vic_is_delayslot in   1   victim instruction is in a branch delay slot
//  eret             in   1   ERET committing at MEM
//  mtc0_we          in   1   MTC0 committing at MEM
//  cp0_waddr        in   5   MTC0 register number
//  cp0_wdata        in   32  MTC0 data
//  cp0_raddr        in   5   MFC0 register number
//  cp0_rdata        out  32  MFC0 data; combinational read of current state
//  flush            out  1   registered one-cycle flush pulse
//  flush_pc         out  32  redirect PC; valid while flush=1
//  timer_int        out  1   timer interrupt pending
//  status_o         out  32  current Status
//  cause_o          out  32  current Cause
//  epc_o            out  32  current EPC
// BEHAVIOUR
//  Reset values:
//   - Status=32'h0040_0000 (BEV=1).
//   - Cause, EPC, BadVAddr, Count, Compare and the divider = 0.
//   - flush=0, flush_pc=0, timer_int=0.
//  Register map:
//   - 8 BadVAddr (RO), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
//   - All other numbers read 0; writes to them are ignored.
//  Write masks:
//   - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV[22] is constant 1.
//   - Cause: only IP[9:8] is writable.
//   - Count, Compare, EPC: all 32 bits writable.
//  Cause.IP[15:10] update every cycle to {hw_int[5]|timer_int, hw_int[4:0]}.
//  int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]).
//   - Computed from current register state (pre-edge).
//  Priority per cycle: int_req > exc_valid > eret > mtc0_we.
//   - A taken event suppresses mtc0_we in that cycle.
//  Taking an interrupt or exception (next edge):
//   - Status.EXL is set.
//   - Cause.ExcCode = 0 for an interrupt, exc_code for an exception.
//   - If EXL was already 1: EPC and Cause.BD are unchanged.
//   - Otherwise: BD = vic_is_delayslot, EPC = vic_inst_addr - (vic_is_delayslot ? 4 : 0).
//   - BadVAddr is written only when exc_valid & exc_badvaddr_we & ~int_req.
//   - flush=1 and flush_pc=EXC_VECTOR on the following cycle.
//  ERET: clears Status.EXL; flush=1 and flush_pc=EPC (pre-edge value) next cycle.
//  flush is high for exactly one cycle per event.
//   - Back-to-back events each produce their own pulse.
//  Timer:
//   - Divider counts 0..COUNT_DIV-1; Count += 1 on wrap; 32'hFFFF_FFFF wraps to 0.
//   - timer_int is set on the edge after Count==Compare (Compare != 0).
//   - timer_int stays set until an MTC0 to Compare clears it.
//   - MTC0 to Count loads the value and clears the divider.
//  Address arithmetic is modulo 2^32.
//  rst asserted mid-operation overrides every event in the same cycle.
// TESTING
//  - Reset: rst=1 for 1 cycle -> status_o=32'h0040_0000, cause_o=0, flush=0.
//  - Interrupt:
//     MTC0 Status=32'h0000_0401, hw_int=6'b000001, vic=(32'h8000_1000,0)
//     -> next cycle flush=1, flush_pc=32'hBFC0_0380, epc_o=32'h8000_1000, ExcCode=0, EXL=1.
//  - Delay-slot exception:
//     exc_valid, exc_code=5'h04, badvaddr 32'h0000_0003, vic=(32'h8000_2004,1)
//     -> EPC=32'h8000_2000, BD=1, BadVAddr=32'h0000_0003.
//  - Nested exception with EXL=1:
//     exc_valid, exc_code=5'h0A -> EPC and BD unchanged, ExcCode=5'h0A, flush pulses.
//  - ERET with EPC=32'h8000_3000
//     -> flush_pc=32'h8000_3000 next cycle, EXL=0; an MTC0 in the same cycle is dropped.
//  - Timer:
//     Compare=10, Count=0, COUNT_DIV=2 -> timer_int rises ~20 cycles later, Cause.IP[15]=1;
//     MTC0 Compare -> timer_int=0 next cycle.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// ---------------------------------------------------------------------------
// cp0_exception_unit
//
// CP0 register file together with the exception / interrupt commit logic that
// sits at the MEM stage. It holds BadVAddr, Count, Compare, Status, Cause and
// EPC. Each cycle it chooses one event: an interrupt first, then a synchronous
// exception, then ERET, then an MTC0 write. A taken interrupt, exception or
// ERET produces a registered one-cycle flush and a redirect PC.
//
// Handshake: there is no valid/ready pairing here. exc_valid, eret and
// mtc0_we are single-cycle commit strobes sampled on the rising clock edge.
// flush is a one-cycle pulse that appears the cycle after the event, and
// flush_pc is meaningful only while flush is high.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   hw_int[5:0]       level-sensitive hardware interrupt lines
//   exc_valid         synchronous exception from the MEM-stage instruction
//   exc_code[4:0]     ExcCode of that exception
//   exc_badvaddr_we   exception carries a faulting address
//   exc_badvaddr      faulting virtual address
//   vic_inst_addr     address of the victim instruction
//   vic_is_delayslot  victim sits in a branch delay slot
//   eret              ERET committing at MEM
//   mtc0_we           MTC0 committing at MEM
//   cp0_waddr/wdata   MTC0 register number and data
//   cp0_raddr/rdata   MFC0 register number and combinational read data
//   flush, flush_pc   registered redirect pulse and target
//   timer_int         timer interrupt pending
//   status_o, cause_o, epc_o  current register values
// ---------------------------------------------------------------------------
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_badvaddr_we,
  input  logic [31:0] exc_badvaddr,
  input  logic [31:0] vic_inst_addr,
  input  logic        vic_is_delayslot,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        timer_int,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Only the writable fields are stored; constant bits are tied in the
  // assembled views below.
  logic [7:0]       status_im;
  logic             status_exl;
  logic             status_ie;
  logic             cause_bd;
  logic [5:0]       cause_ip_hw;
  logic [1:0]       cause_ip_sw;
  logic [4:0]       cause_exc;
  logic [31:0]      epc_q;
  logic [31:0]      badvaddr_q;
  logic [31:0]      count_q;
  logic [31:0]      compare_q;
  logic [DIV_W-1:0] div_q;
  logic             timer_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic        int_req;
  logic        take_exc;
  logic        do_eret;
  logic        do_mtc0;
  logic [31:0] epc_target;

  assign status_w = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_w  = {cause_bd, 15'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};

  // Interrupt request is evaluated on the registered state, so a change in
  // hw_int needs one edge to reach Cause.IP before it can be taken.
  assign int_req  = status_ie & ~status_exl &
                    (|({cause_ip_hw, cause_ip_sw} & status_im));
  assign take_exc = int_req | exc_valid;
  assign do_eret  = ~take_exc & eret;
  assign do_mtc0  = ~take_exc & ~eret & mtc0_we;

  // A delay-slot victim restarts at the branch, one word earlier (mod 2^32).
  assign epc_target = vic_inst_addr - (vic_is_delayslot ? 32'd4 : 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im   <= 8'd0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_hw <= 6'd0;
      cause_ip_sw <= 2'd0;
      cause_exc   <= 5'd0;
      epc_q       <= 32'd0;
      badvaddr_q  <= 32'd0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      div_q       <= '0;
      timer_q     <= 1'b0;
      flush_q     <= 1'b0;
      flush_pc_q  <= 32'd0;
    end else begin
      cause_ip_hw <= {hw_int[5] | timer_q, hw_int[4:0]};
      flush_q     <= 1'b0;

      // Free-running Count; an MTC0 to Count restarts the divider phase.
      if (do_mtc0 && cp0_waddr == REG_COUNT) begin
        count_q <= cp0_wdata;
        div_q   <= '0;
      end else if (div_q == DIV_LAST) begin
        div_q   <= '0;
        count_q <= count_q + 32'd1;
      end else begin
        div_q   <= div_q + DIV_ONE;
      end

      // Timer is sticky; only rewriting Compare acknowledges it.
      if (do_mtc0 && cp0_waddr == REG_COMPARE) begin
        timer_q <= 1'b0;
      end else if (count_q == compare_q && compare_q != 32'd0) begin
        timer_q <= 1'b1;
      end

      if (take_exc) begin
        status_exl <= 1'b1;
        cause_exc  <= int_req ? 5'd0 : exc_code;
        // A nested event keeps the original return point.
        if (!status_exl) begin
          cause_bd <= vic_is_delayslot;
          epc_q    <= epc_target;
        end
        if (!int_req && exc_badvaddr_we) begin
          badvaddr_q <= exc_badvaddr;
        end
        flush_q    <= 1'b1;
        flush_pc_q <= EXC_VECTOR;
      end else if (do_eret) begin
        status_exl <= 1'b0;
        flush_q    <= 1'b1;
        flush_pc_q <= epc_q;
      end else if (do_mtc0) begin
        case (cp0_waddr)
          REG_COMPARE: compare_q <= cp0_wdata;
          REG_STATUS: begin
            status_im  <= cp0_wdata[15:8];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
          end
          REG_CAUSE:   cause_ip_sw <= cp0_wdata[9:8];
          REG_EPC:     epc_q       <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr_q;
      REG_COUNT:    cp0_rdata = count_q;
      REG_COMPARE:  cp0_rdata = compare_q;
      REG_STATUS:   cp0_rdata = status_w;
      REG_CAUSE:    cp0_rdata = cause_w;
      REG_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign flush     = flush_q;
  assign flush_pc  = flush_pc_q;
  assign timer_int = timer_q;
  assign status_o  = status_w;
  assign cause_o   = cause_w;
  assign epc_o     = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_exception_unit
//
// Bench for cp0_exception_unit. Inputs change on the falling edge; register
// state is compared against a behavioural CP0 model every cycle, and every
// redirect the model expects is queued and matched against flush/flush_pc by
// an independent monitor shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_cp0_exception_unit;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam int          CDIV    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_badvaddr_we;
  logic [31:0] exc_badvaddr;
  logic [31:0] vic_inst_addr;
  logic        vic_is_delayslot;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        timer_int;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  cp0_exception_unit #(
    .EXC_VECTOR(EXC_VEC),
    .COUNT_DIV (CDIV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hw_int          (hw_int),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .exc_badvaddr_we (exc_badvaddr_we),
    .exc_badvaddr    (exc_badvaddr),
    .vic_inst_addr   (vic_inst_addr),
    .vic_is_delayslot(vic_is_delayslot),
    .eret            (eret),
    .mtc0_we         (mtc0_we),
    .cp0_waddr       (cp0_waddr),
    .cp0_wdata       (cp0_wdata),
    .cp0_raddr       (cp0_raddr),
    .cp0_rdata       (cp0_rdata),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .timer_int       (timer_int),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Registers are held as whole 32-bit architectural values; writes go
  // through field masks.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  int          m_div;
  logic        m_timer;
  logic        model_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // stimulus for the next cycle
  logic        s_rst, s_exc, s_bwe, s_vbd, s_eret, s_mtc0;
  logic [5:0]  s_hw;
  logic [4:0]  s_code, s_waddr, s_raddr;
  logic [31:0] s_badv, s_vaddr, s_wdata;

  task automatic clear_stim();
    s_rst = 0; s_hw = 0; s_exc = 0; s_code = 0; s_bwe = 0; s_badv = 0;
    s_vaddr = 0; s_vbd = 0; s_eret = 0; s_mtc0 = 0; s_waddr = 0; s_wdata = 0;
    s_raddr = 0;
  endtask

  // Advance the model by one rising edge using the current stimulus.
  task automatic model_step();
    logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
    int          n_div;
    logic        n_timer, irq, taken;
    if (s_rst) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
      m_count = 0; m_compare = 0; m_div = 0; m_timer = 0;
      model_valid = 1'b1;
      return;
    end
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
    n_count = m_count; n_compare = m_compare; n_timer = m_timer;
    irq   = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
    taken = irq || s_exc;
    n_cause[15:10] = {s_hw[5] | m_timer, s_hw[4:0]};
    if (m_count == m_compare && m_compare != 0) n_timer = 1'b1;
    n_div = (m_div + 1) % CDIV;
    if (n_div == 0) n_count = m_count + 32'd1;
    if (taken) begin
      n_status[1]   = 1'b1;
      n_cause[6:2]  = irq ? 5'd0 : s_code;
      if (!m_status[1]) begin
        n_cause[31] = s_vbd;
        n_epc       = s_vbd ? s_vaddr - 32'd4 : s_vaddr;
      end
      if (!irq && s_bwe) n_badv = s_badv;
      exp_q.push_back(EXC_VEC);
    end else if (s_eret) begin
      n_status[1] = 1'b0;
      exp_q.push_back(m_epc);
    end else if (s_mtc0) begin
      case (s_waddr)
        5'd9:  begin n_count = s_wdata; n_div = 0; end
        5'd11: begin n_compare = s_wdata; n_timer = 1'b0; end
        5'd12: n_status = (m_status & ~STATUS_WMASK) | (s_wdata & STATUS_WMASK);
        5'd13: n_cause  = (n_cause & ~CAUSE_WMASK) | (s_wdata & CAUSE_WMASK);
        5'd14: n_epc    = s_wdata;
        default: ;
      endcase
    end
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
    m_count = n_count; m_compare = n_compare; m_div = n_div; m_timer = n_timer;
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle();
    @(negedge clk);
    if (model_valid) begin
      check32("status_o", status_o, m_status);
      check32("cause_o", cause_o, m_cause);
      check32("epc_o", epc_o, m_epc);
      check32("timer_int", {31'd0, timer_int}, {31'd0, m_timer});
    end
    rst = s_rst; hw_int = s_hw; exc_valid = s_exc; exc_code = s_code;
    exc_badvaddr_we = s_bwe; exc_badvaddr = s_badv; vic_inst_addr = s_vaddr;
    vic_is_delayslot = s_vbd; eret = s_eret; mtc0_we = s_mtc0;
    cp0_waddr = s_waddr; cp0_wdata = s_wdata; cp0_raddr = s_raddr;
    #1;
    if (model_valid) check32("cp0_rdata", cp0_rdata, m_read(s_raddr));
    model_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic rand_stim();
    clear_stim();
    if ($urandom_range(0, 7) == 0) s_hw = 6'($urandom_range(1, 63));
    s_exc  = ($urandom_range(0, 9) == 0);
    s_code = 5'($urandom);
    s_bwe  = 1'($urandom_range(0, 1));
    s_badv = $urandom;
    s_eret = ($urandom_range(0, 7) == 0);
    s_mtc0 = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 7))
      0: s_waddr = 5'd8;
      1: s_waddr = 5'd9;
      2: s_waddr = 5'd11;
      3: s_waddr = 5'd12;
      4: s_waddr = 5'd13;
      5: s_waddr = 5'd14;
      6: s_waddr = 5'd0;
      default: s_waddr = 5'($urandom);
    endcase
    s_wdata = $urandom;
    if (s_waddr == 5'd9 && $urandom_range(0, 1) == 1) s_wdata = 32'hFFFF_FFF0 + $urandom_range(0, 15);
    if (s_waddr == 5'd11) s_wdata = m_count + $urandom_range(0, 6);
    if (s_waddr == 5'd12 && $urandom_range(0, 1) == 1) begin
      s_wdata[1] = 1'b0;
      s_wdata[0] = 1'b1;
    end
    if ($urandom_range(0, 15) == 0) s_vaddr = $urandom_range(0, 3) * 4;
    else s_vaddr = $urandom & 32'hFFFF_FFFC;
    s_vbd   = 1'($urandom_range(0, 1));
    s_raddr = 5'($urandom);
  endtask

  // ---------------- flush monitor ----------------
  always @(posedge clk) begin
    logic [31:0] want;
    #2;
    if (flush === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL flush_unexpected: got flush=1 pc=%h, expected flush=0", flush_pc);
      end else begin
        want = exp_q.pop_front();
        if (flush_pc === want) n_pass++;
        else $display("FAIL flush_pc: got %h, expected %h", flush_pc, want);
      end
    end else if (exp_q.size() != 0) begin
      n_checks++;
      want = exp_q.pop_front();
      $display("FAIL flush_missing: got flush=%b, expected flush=1 pc=%h", flush, want);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int fired;
    clear_stim();
    rst = 1; hw_int = 0; exc_valid = 0; exc_code = 0; exc_badvaddr_we = 0;
    exc_badvaddr = 0; vic_inst_addr = 0; vic_is_delayslot = 0; eret = 0;
    mtc0_we = 0; cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0;

    // reset
    s_rst = 1; do_cycle(); clear_stim();
    after_edge();
    check32("rst_status", status_o, 32'h0040_0000);
    check32("rst_cause", cause_o, 32'd0);
    check32("rst_flush", {31'd0, flush}, 32'd0);

    // interrupt on hw_int[0]
    s_mtc0 = 1; s_waddr = 5'd12; s_wdata = 32'h0000_0401; s_hw = 6'b000001;
    do_cycle(); clear_stim();
    s_hw = 6'b000001; s_vaddr = 32'h8000_1000; s_vbd = 0;
    do_cycle(); clear_stim();
    after_edge();
    check32("int_flush", {31'd0, flush}, 32'd1);
    check32("int_flush_pc", flush_pc, 32'hBFC0_0380);
    check32("int_epc", epc_o, 32'h8000_1000);
    check32("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
    check32("int_exl", {31'd0, status_o[1]}, 32'd1);
    s_eret = 1; do_cycle(); clear_stim();

    // delay-slot exception with bad address
    s_exc = 1; s_code = 5'h04; s_bwe = 1; s_badv = 32'h0000_0003;
    s_vaddr = 32'h8000_2004; s_vbd = 1; s_raddr = 5'd8;
    do_cycle(); clear_stim();
    after_edge();
    check32("ds_epc", epc_o, 32'h8000_2000);
    check32("ds_bd", {31'd0, cause_o[31]}, 32'd1);
    check32("ds_badvaddr", cp0_rdata, 32'h0000_0003);

    // nested exception keeps EPC/BD
    s_exc = 1; s_code = 5'h0A; s_vaddr = 32'h8000_5000; s_vbd = 0;
    do_cycle(); clear_stim();
    after_edge();
    check32("nest_epc", epc_o, 32'h8000_2000);
    check32("nest_bd", {31'd0, cause_o[31]}, 32'd1);
    check32("nest_exccode", {27'd0, cause_o[6:2]}, 32'h0000_000A);
    check32("nest_flush", {31'd0, flush}, 32'd1);

    // ERET with a competing MTC0 that must be dropped
    s_mtc0 = 1; s_waddr = 5'd14; s_wdata = 32'h8000_3000;
    do_cycle(); clear_stim();
    s_eret = 1; s_mtc0 = 1; s_waddr = 5'd14; s_wdata = 32'h1234_5678;
    do_cycle(); clear_stim();
    after_edge();
    check32("eret_flush_pc", flush_pc, 32'h8000_3000);
    check32("eret_exl", {31'd0, status_o[1]}, 32'd0);
    check32("eret_epc_kept", epc_o, 32'h8000_3000);

    // timer: Compare=10, Count=0, divide by 2
    s_mtc0 = 1; s_waddr = 5'd11; s_wdata = 32'd10;
    do_cycle(); clear_stim();
    s_mtc0 = 1; s_waddr = 5'd9; s_wdata = 32'd0;
    do_cycle(); clear_stim();
    fired = 0;
    for (int i = 1; i <= 40; i++) begin
      do_cycle();
      after_edge();
      if (timer_int === 1'b1) begin
        fired = i;
        break;
      end
    end
    check32("timer_latency", 32'(fired), 32'd21);
    do_cycle();
    after_edge();
    check32("timer_ip7", {31'd0, cause_o[15]}, 32'd1);
    s_mtc0 = 1; s_waddr = 5'd11; s_wdata = 32'h0000_0100;
    do_cycle(); clear_stim();
    after_edge();
    check32("timer_ack", {31'd0, timer_int}, 32'd0);

    // Count wraps from all-ones to zero
    s_mtc0 = 1; s_waddr = 5'd9; s_wdata = 32'hFFFF_FFFF;
    do_cycle(); clear_stim();
    s_raddr = 5'd9;
    do_cycle();
    do_cycle();
    after_edge();
    check32("count_wrap", cp0_rdata, 32'd0);
    clear_stim();

    // reset wins over a simultaneous exception
    s_rst = 1; s_exc = 1; s_code = 5'h05;
    do_cycle(); clear_stim();
    after_edge();
    check32("rst_mid_flush", {31'd0, flush}, 32'd0);
    check32("rst_mid_status", status_o, 32'h0040_0000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_stim();
      do_cycle();
    end
    clear_stim();
    do_cycle();
    after_edge();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending flushes, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
